// File: rtl/int_to_fp_no_ctrl_pkg.sv
// Shared FPU definitions for the integer-to-single converter.
// Holds rounding-mode encodings, fflags bit indices, op field positions,
// the FP32 exponent bias and a 64-bit leading-zero count helper.
package int_to_fp_no_ctrl_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

  localparam int unsigned OP_DOUBLE_BIT   = 2;
  localparam int unsigned OP_WIDE_BIT     = 1;
  localparam int unsigned OP_UNSIGNED_BIT = 0;

  localparam int unsigned FP32_BIAS = 127;

  // Returns 64 for a zero input; the highest set bit wins the scan.
  function automatic logic [6:0] lzc64(input logic [63:0] v);
    logic [6:0] n;
    n = 7'd64;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = 7'(63 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/int_to_fp_no_ctrl_if.sv
// Operand/result bus of the integer-to-single converter.
// master: drives op_i, a_i, rm_i, in_valid_i, out_ready_i; observes outputs.
// slave : the converter; drives in_ready_o, out_valid_o, result_o, fflags_o.
interface int_to_fp_no_ctrl_if;
  logic [2:0]  op_i;
  logic [63:0] a_i;
  logic [2:0]  rm_i;
  logic        in_valid_i;
  logic        out_ready_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [63:0] result_o;
  logic [4:0]  fflags_o;

  modport master (
    output op_i, a_i, rm_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, fflags_o
  );

  modport slave (
    input  op_i, a_i, rm_i, in_valid_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, fflags_o
  );
endinterface

// File: rtl/int_to_fp_no_ctrl_core.sv
// Combinational int32/uint32/int64/uint64 -> fp32 conversion core.
// Ports: op (wide, unsigned), a (operand), rm (rounding mode) in;
//        res (fp32 bits) and flags ({NV,DZ,OF,UF,NX}) out.
module int_to_fp_no_ctrl_core
  import int_to_fp_no_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [2:0]  rm,
  output logic [31:0] res,
  output logic [4:0]  flags
);

  logic        is_wide;
  logic        is_uns;
  logic [63:0] src;
  logic        sign;
  logic [63:0] mag;
  logic [6:0]  lz;
  logic [63:0] norm;
  logic [23:0] mant;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [24:0] mant_rnd;
  logic        carry;
  logic [8:0]  exp_full;

  assign is_wide = op[OP_WIDE_BIT];
  assign is_uns  = op[OP_UNSIGNED_BIT];

  always_comb begin
    if (is_wide)     src = a;
    else if (is_uns) src = {32'd0, a[31:0]};
    else             src = {{32{a[31]}}, a[31:0]};
  end

  assign sign = !is_uns && src[63];
  // Two's-complement negate; -2^63 maps to 2^63 as an unsigned magnitude.
  assign mag  = sign ? (~src + 64'd1) : src;
  assign lz   = lzc64(mag);
  assign norm = mag << lz;

  assign mant   = norm[63:40];
  assign guard  = norm[39];
  assign sticky = |norm[38:0];

  always_comb begin
    round_up = 1'b0;
    case (rm)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sign && (guard || sticky);
      RM_RUP:  round_up = !sign && (guard || sticky);
      RM_RMM:  round_up = guard;
      default: round_up = guard && (sticky || mant[0]);
    endcase
  end

  assign mant_rnd = {1'b0, mant} + {24'd0, round_up};
  // On carry-out the significand is exactly 2^24, so the fraction is zero.
  assign carry    = mant_rnd[24];
  assign exp_full = 9'(FP32_BIAS) + 9'd63 - {2'b00, lz} + {8'd0, carry};

  always_comb begin
    flags           = '0;
    flags[FFLAG_NV] = 1'b0;
    flags[FFLAG_DZ] = 1'b0;
    flags[FFLAG_OF] = 1'b0;
    flags[FFLAG_UF] = 1'b0;
    flags[FFLAG_NX] = guard || sticky;
    if (mag == 64'd0) begin
      res = 32'd0;
    end else begin
      res = {sign, exp_full[7:0], carry ? 23'd0 : mant_rnd[22:0]};
    end
  end

endmodule

// File: rtl/int_to_fp_no_ctrl.sv
// Two-stage pipelined integer-to-single converter (fcvt.s.w/wu/l/lu).
// Ports: clk, rst_n (synchronous, active-low), bus (slave side of
// int_to_fp_no_ctrl_if carrying op/a/rm, valid/ready and result/fflags).
// Optional macro INT2FP_NANBOX_EN: NaN-box single results (upper word all ones).
module int_to_fp_no_ctrl
  import int_to_fp_no_ctrl_pkg::*;
#(
  parameter int unsigned EXPWIDTH    = 8,
  parameter int unsigned PRECISION   = 24,
  parameter int unsigned SOFT_THREAD = 4
) (
  input logic              clk,
  input logic              rst_n,
  int_to_fp_no_ctrl_if.slave bus
);

  if (!(EXPWIDTH == 8 && PRECISION == 24 && SOFT_THREAD > 0)) begin : g_param_check
    $error("int_to_fp_no_ctrl supports only fp32 results");
  end

  logic        v1_q, v1_d;
  logic        v2_q, v2_d;
  logic        is_single1_q;
  logic [1:0]  op1_q;
  logic [63:0] a1_q;
  logic [2:0]  rm1_q;
  logic [31:0] res2_q;
  logic [4:0]  flags2_q;
  logic        is_single2_q;

  logic        stall;
  logic        en1;
  logic        en2;
  logic [31:0] core_res;
  logic [4:0]  core_flags;

  assign stall = v2_q && !bus.out_ready_i;
  assign en1   = bus.in_valid_i && !(v1_q && stall);
  assign en2   = v1_q && !stall;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (!(v1_q && stall)) v1_d = bus.in_valid_i;
    if (!stall)           v2_d = v1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      is_single1_q <= 1'b0;
      op1_q        <= '0;
      a1_q         <= '0;
      rm1_q        <= '0;
      res2_q       <= '0;
      flags2_q     <= '0;
      is_single2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (en1) begin
        is_single1_q <= !bus.op_i[OP_DOUBLE_BIT];
        op1_q        <= bus.op_i[1:0];
        a1_q         <= bus.a_i;
        rm1_q        <= bus.rm_i;
      end
      if (en2) begin
        res2_q       <= core_res;
        flags2_q     <= core_flags;
        is_single2_q <= is_single1_q;
      end
    end
  end

  int_to_fp_no_ctrl_core u_core (
    .op    (op1_q),
    .a     (a1_q),
    .rm    (rm1_q),
    .res   (core_res),
    .flags (core_flags)
  );

`ifdef INT2FP_NANBOX_EN
  localparam logic [31:0] UpperWord = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] UpperWord = 32'h0000_0000;
`endif

  assign bus.in_ready_o  = !(!bus.out_ready_i && v1_q && v2_q);
  assign bus.out_valid_o = v2_q;
  assign bus.result_o    = is_single2_q ? {UpperWord, res2_q} : 64'd0;
  assign bus.fflags_o    = is_single2_q ? flags2_q : 5'd0;

endmodule

// File: tb/tb_int_to_fp_no_ctrl.sv
// Directed self-checking bench for int_to_fp_no_ctrl.
module tb_int_to_fp_no_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  int_to_fp_no_ctrl_if bus ();

  int_to_fp_no_ctrl #(
    .EXPWIDTH    (8),
    .PRECISION   (24),
    .SOFT_THREAD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef INT2FP_NANBOX_EN
  localparam logic [31:0] Hi = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] Hi = 32'h0000_0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then confirm 2-cycle latency, result and flags.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [63:0] a,
                         input logic [2:0] rm, input logic single, input logic [31:0] exp_res,
                         input logic [4:0] exp_flags);
    bus.op_i        = op;
    bus.a_i         = a;
    bus.rm_i        = rm;
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    check_eq({tag, "_rdy"}, {63'd0, bus.in_ready_o}, 64'd1);
    tick();
    bus.in_valid_i = 1'b0;
    check_eq({tag, "_lat1"}, {63'd0, bus.out_valid_o}, 64'd0);
    tick();
    check_eq({tag, "_vld"}, {63'd0, bus.out_valid_o}, 64'd1);
    check_eq({tag, "_res"}, bus.result_o, single ? {Hi, exp_res} : 64'd0);
    check_eq({tag, "_flg"}, {59'd0, bus.fflags_o}, {59'd0, exp_flags});
    tick();
  endtask

  logic [31:0] stream_exp [8];
  int          tx, rx, cnt, acc, drn;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n           = 1'b0;
    bus.op_i        = '0;
    bus.a_i         = '0;
    bus.rm_i        = '0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    check_eq("rst_valid", {63'd0, bus.out_valid_o}, 64'd0);
    check_eq("rst_result", bus.result_o, 64'd0);
    check_eq("rst_flags", {59'd0, bus.fflags_o}, 64'd0);
    check_eq("rst_ready", {63'd0, bus.in_ready_o}, 64'd1);

    run_one("one",     3'b000, 64'd1,                 3'b000, 1'b1, 32'h3F80_0000, 5'd0);
    run_one("m_one",   3'b000, 64'hFFFF_FFFF,         3'b000, 1'b1, 32'hBF80_0000, 5'd0);
    run_one("rne_nx",  3'b000, 64'h0100_0001,         3'b000, 1'b1, 32'h4B80_0000, 5'd1);
    run_one("rup_nx",  3'b000, 64'h0100_0001,         3'b011, 1'b1, 32'h4B80_0001, 5'd1);
    run_one("rmm",     3'b000, 64'h0100_0001,         3'b100, 1'b1, 32'h4B80_0001, 5'd1);
    run_one("rm_101",  3'b000, 64'h0100_0001,         3'b101, 1'b1, 32'h4B80_0000, 5'd1);
    run_one("rdn_neg", 3'b000, 64'hFEFF_FFFF,         3'b010, 1'b1, 32'hCB80_0001, 5'd1);
    run_one("int_min", 3'b000, 64'h8000_0000,         3'b000, 1'b1, 32'hCF00_0000, 5'd0);
    run_one("u32_max", 3'b001, 64'hFFFF_FFFF,         3'b000, 1'b1, 32'h4F80_0000, 5'd1);
    run_one("u32_rtz", 3'b001, 64'hFFFF_FFFF,         3'b001, 1'b1, 32'h4F7F_FFFF, 5'd1);
    run_one("u64_max", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b1, 32'h5F80_0000, 5'd1);
    run_one("i64_min", 3'b010, 64'h8000_0000_0000_0000, 3'b000, 1'b1, 32'hDF00_0000, 5'd0);
    run_one("zero_rdn", 3'b000, 64'd0,                3'b010, 1'b1, 32'h0000_0000, 5'd0);
    run_one("dbl_dst", 3'b100, 64'h0100_0001,         3'b000, 1'b0, 32'h0000_0000, 5'd0);

    // Stream 1..8 with a 3-cycle downstream stall in the middle.
    stream_exp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                   32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    tx  = 0;
    rx  = 0;
    cnt = 0;
    bus.op_i = 3'b000;
    bus.rm_i = 3'b000;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.in_valid_i  = (tx < 8);
      bus.a_i         = 64'(tx + 1);
      bus.out_ready_i = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      check_eq("stream_rdy", {63'd0, bus.in_ready_o},
               {63'd0, !(!bus.out_ready_i && cnt == 2)});
      acc = (bus.in_valid_i && bus.in_ready_o) ? 1 : 0;
      drn = 0;
      if (bus.out_valid_o && bus.out_ready_i) begin
        drn = 1;
        if (rx < 8) check_eq("stream_res", bus.result_o, {Hi, stream_exp[rx]});
        else        check_eq("stream_extra", 64'd1, 64'd0);
        rx++;
      end
      tx  = tx + acc;
      cnt = cnt + acc - drn;
      tick();
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    check_eq("stream_count", 64'(rx), 64'd8);

    // Reset with two ops in flight.
    bus.a_i        = 64'd3;
    bus.in_valid_i = 1'b1;
    tick();
    bus.a_i = 64'd5;
    tick();
    bus.in_valid_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mrst_valid", {63'd0, bus.out_valid_o}, 64'd0);
    check_eq("mrst_result", bus.result_o, 64'd0);
    check_eq("mrst_ready", {63'd0, bus.in_ready_o}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("mrst_stale", {63'd0, bus.out_valid_o}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_to_fp_no_ctrl.md
# int_to_fp_no_ctrl

Two-stage pipelined integer-to-single-precision converter. It implements fcvt.s.w/wu/l/lu and is the reverse-direction companion of the FPU's float-to-integer unit. It uses the same 64-bit operand bus, op/rm encoding, valid/ready pipeline discipline and 2-cycle latency, so the FPU arbiter can treat both converters identically. It carries no control sideband.

## Interface
Parameters:
- EXPWIDTH, 8, result exponent width.
- PRECISION, 24, result significand width including the hidden bit.
- SOFT_THREAD, 4, carried for arbiter uniformity; unused internally.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- op_i  in  3  operation select:
  - [2]=1 means double destination, which is unsupported.
  - [1]=1 means 64-bit source.
  - [0]=1 means unsigned source.
- a_i  in  64  integer operand. 32-bit ops use a_i[31:0] only.
- rm_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- in_valid_i  in  1  input valid.
- out_ready_i  in  1  downstream ready.
- in_ready_o  out  1  input accepted this cycle.
- out_valid_o  out  1  result valid.
- result_o  out  64  fp32 result in [31:0].
- fflags_o  out  5  {NV,DZ,OF,UF,NX}.

## Operation
- Stage 1 registers: is_single = !op_i[2], op_i[1:0], a_i, rm_i. The register enable is en1 = in_valid_i && !(v1 && v2 && !out_ready_i).
- Combinational core between the stages:
  - Select source width; sign-extend (signed) or zero-extend (unsigned) the 32-bit source to 64 bits.
  - sign = source MSB for signed ops, else 0. mag = |source| as a 64-bit unsigned. -2^63 is handled with no overflow.
  - lz = leading-zero count of mag (0..64). Normalize with mag << lz.
  - Keep 24 bits. guard = next bit; sticky = OR of all remaining bits.
  - Round up per rm:
    - RNE: g && (s || lsb).
    - RTZ: never.
    - RDN: sign && (g||s).
    - RUP: !sign && (g||s).
    - RMM: g.
    - rm 101–111 behaves as RNE and sets no flag.
  - A significand carry-out increments the exponent.
  - Biased exponent = 127 + 63 − lz (+1 on carry).
  - mag == 0 gives +0 (0x00000000) in every rm, with flags 0.
- Flags: NX = g||s. NV, DZ, OF and UF are always 0, because |2^64| < 2^128.
- Stage 2 registers the core result, flags and is_single. The enable is en2 = v1 && !(v2 && !out_ready_i).
- Output: when is_single_reg2=0, result_o = 0 and fflags_o = 0.

## Timing
- Latency is 2 cycles from accept to out_valid_o. Throughput is 1 per cycle while out_ready_i=1.
- in_ready_o = !(!out_ready_i && v1 && v2). in_ready_o depends combinationally on out_ready_i.
- Valid pipeline:
  - v1 <= in_valid_i unless (v1&&v2&&!out_ready_i).
  - v2 <= v1 unless (v2&&!out_ready_i).
  - out_valid_o = v2.
- Stall (out_ready_i=0 with v2=1): stage 2 holds its result and flags stable. Stage 1 also holds if v1=1. A bubble in v1 still fills.
- Simultaneous accept and drain in one cycle is lossless.
- Reset: a sampled rst_n=0 clears v1, v2 and all data registers. After reset, out_valid_o=0, result_o=0 and fflags_o=0, and in_ready_o=1. Reset mid-operation discards in-flight results with no partial output.

## Configuration
- INT2FP_NANBOX_EN:
  - Defined: for single results, result_o[63:32] = 32'hFFFFFFFF (RISC-V NaN-boxing).
  - Undefined: result_o[63:32] = 0.
  - In both cases, result_o is all-zero after reset and for unsupported ops.

## Structure
- The shared FPU package holds:
  - rounding-mode constants (RM_RNE..RM_RMM);
  - fflags bit indices;
  - op field positions;
  - FP32 bias (127).
- The only natural sub-module is int_to_fp_core: purely combinational, holding abs, LZC, normalize and round. The wrapper owns the handshake and both register stages.

## Test plan
- int32 1, RNE -> 0x3F800000, flags 0. int32 −1 -> 0xBF800000. Each appears exactly 2 cycles after accept.
- int32 0x01000001, RNE -> 0x4B800000 with NX=1. Same operand with RUP -> 0x4B800001 with NX=1.
- Edge values:
  - int32 0x80000000 -> 0xCF000000, NX=0.
  - uint32 0xFFFFFFFF, RNE -> 0x4F800000, NX=1.
  - uint64 all-ones -> 0x5F800000, NX=1.
  - Zero in RDN -> 0x00000000.
- op_i[2]=1 with any operand -> result_o=0 and fflags_o=0 while valid still propagates. With INT2FP_NANBOX_EN, single results show upper bits 0xFFFFFFFF.
- Back-to-back stream of 8 ops with out_ready_i low for 3 cycles mid-stream:
  - in_ready_o drops only when v1 and v2 are both set.
  - No result is lost or duplicated, and the results stay in order.
- Assert rst_n low for 1 cycle with 2 ops in flight -> the next cycle has out_valid_o=0, result_o=0 and in_ready_o=1, and no stale result appears later.
